reversible_alu_pipe: RTL and testbench
======================================

# reversible_alu_pipe

Parametrised, pipelined successor to the combinational `reversible_alu_32bit`. It wraps a WIDTH-generic ALU datapath in a two-stage valid/ready pipeline. It adds a sticky carry register for multi-word add chains, signed-overflow and illegal-opcode flags, and a garbage output G that preserves the information needed to invert the reversible operations. It sits between the operand sequencer and the result writeback, at full throughput of one operation per cycle.

## Interface
- `WIDTH`, 32: operand and result width, ≥ 4.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: block accepts the beat this cycle.
- `A`, `B`  in  WIDTH each: operands.
- `S`  in  4: operation select.
- `MODE`  in  1: 0 = arithmetic, 1 = logic/shift.
- `carry_clr`  in  1: clears the sticky carry; sampled only with an accepted beat.
- `out_valid`  out  1: result beat valid.
- `out_ready`  in  1: consumer accepts the result.
- `F`  out  WIDTH: result.
- `G`  out  WIDTH: garbage/preserved operand. Equals A for ADD, SUB, ADDC and XOR; 0 otherwise.
- `carry_out`, `zero_flag`, `eq_flag`, `ovf_flag`, `err`  out  1 each: flags.

## Operation
- Arithmetic ops, MODE=0. All are computed as WIDTH+1-bit sums, with carry_out = bit WIDTH.
  - S=0 ADD: A+B.
  - S=1 SUB: A+~B+1, so carry_out=1 means no borrow.
  - S=2 INC: A+1.
  - S=3 DEC: A+all-ones.
  - S=4 NEG: ~A+1.
  - S=5 ADDC: A+B+carry_q.
  - S=6..15: F=A, carry_out=0, err=1.
- Logic ops, MODE=1. carry_out is the shifted-out bit for S=8/9 and 0 otherwise.
  - S=0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NOT A, 5 NAND, 6 NOR.
  - S=7: pass B.
  - S=8 SHL1: A<<1.
  - S=9 SHR1: logical right shift by 1.
  - S=10 ROL1, S=11 ROR1.
  - S=12..15: F=0, err=1.
- ovf_flag:
  - ADD, ADDC and INC: operand sign bits equal and result sign differs.
  - SUB, DEC and NEG: two's-complement overflow (e.g. NEG of the most-negative value).
  - 0 for logic ops.
- zero_flag = (F==0). eq_flag = (A==B) for every op.
- Sticky carry `carry_q`:
  - On every accepted arithmetic beat with err=0, carry_q takes that beat's carry_out.
  - Logic and err beats leave carry_q unchanged.
  - carry_clr=1 on an accepted beat forces carry_q to 0 before that beat's ADDC, i.e. that beat uses carry-in 0.
  - Back-to-back ADDC beats chain correctly with no bubbles.
- Reversibility: for ADD, SUB and XOR, the pair (F, G) uniquely determines (A, B).

## Timing
- Reset values: in_ready=1; out_valid=0; F, G and all flags 0; carry_q=0; both stages empty.
- Stage 1: on the acceptance edge k, it registers the core result and flags; carry_q also updates on edge k.
- Stage 2: the output register loads on edge k+1, so out_valid is high after edge k+1. Latency is 2 edges.
- Control:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - The whole pipeline stalls when advance=0.
- Throughput is 1 beat per cycle with out_ready held high.
- While out_valid=1 and out_ready=0, F, G and the flags hold stable.
- in_valid=1 with in_ready=0 is not a transfer, and carry_q does not change.
- Reset asserted mid-stream clears both stages in the same edge. In-flight beats are discarded and no out_valid is produced for them.

## Structure
- Package `alu_pkg`: opcode localparams (OP_ADD..OP_ADDC, OP_AND..OP_ROR), MODE_ARITH and MODE_LOGIC.
- Sub-module `reversible_alu_core`: purely combinational and WIDTH-parametrised.
  - Inputs: A, B, S, MODE, cin.
  - Outputs: F, G, carry_out, ovf, err, eq.
- The top level holds the pipeline registers, the handshake and carry_q.

## Test plan
1. WIDTH=32, ADD A=5, B=3, out_ready=1 → F=8, G=5, carry_out=0, zero=0, eq=0. out_valid appears exactly 2 edges after acceptance.
2. WIDTH=32, ADD A=0xFFFFFFFF, B=1, then back-to-back ADDC A=0, B=0 → first beat F=0, carry_out=1, zero=1. Second beat F=1, carry_out=0.
3. WIDTH=8, SUB A=0x80, B=1 → F=0x7F, ovf=1, carry_out=1. Then NEG A=0x80 → F=0x80, ovf=1.
4. Hold out_ready=0 for 5 cycles while streaming XOR, OR and AND beats → at most 2 beats buffered, in_ready=0 and outputs stable while stalled. All 3 results arrive in order once out_ready=1.
5. MODE=1, S=13 and MODE=0, S=9 → err=1, carry_q unchanged. Verify with a following ADDC A=0, B=0 after a carry-producing ADD.
6. Assert rst for 1 cycle with 2 beats in flight → out_valid=0, carry_q=0, and neither beat is ever emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode and mode encodings shared by the reversible ALU core and its pipeline wrapper.
package alu_pkg;

    typedef logic [3:0] opcode_t;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    localparam opcode_t OP_ADD  = 4'd0;
    localparam opcode_t OP_SUB  = 4'd1;
    localparam opcode_t OP_INC  = 4'd2;
    localparam opcode_t OP_DEC  = 4'd3;
    localparam opcode_t OP_NEG  = 4'd4;
    localparam opcode_t OP_ADDC = 4'd5;

    localparam opcode_t OP_AND  = 4'd0;
    localparam opcode_t OP_OR   = 4'd1;
    localparam opcode_t OP_XOR  = 4'd2;
    localparam opcode_t OP_XNOR = 4'd3;
    localparam opcode_t OP_NOT  = 4'd4;
    localparam opcode_t OP_NAND = 4'd5;
    localparam opcode_t OP_NOR  = 4'd6;
    localparam opcode_t OP_PASSB = 4'd7;
    localparam opcode_t OP_SHL  = 4'd8;
    localparam opcode_t OP_SHR  = 4'd9;
    localparam opcode_t OP_ROL  = 4'd10;
    localparam opcode_t OP_ROR  = 4'd11;

endpackage

// File: rtl/reversible_alu_core.sv
// Combinational WIDTH-generic ALU datapath; G keeps A for the invertible ops so (F, G) recovers (A, B).
module reversible_alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             MODE,
    input  logic             cin,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] G,
    output logic             carry_out,
    output logic             ovf,
    output logic             err,
    output logic             eq
);

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_c;
    logic [WIDTH:0]   sum;

    // Every arithmetic op is one adder with remapped operands, so overflow is a single sign test.
    always_comb begin
        add_x = A;
        add_y = B;
        add_c = 1'b0;
        case (S)
            OP_SUB:  begin add_y = ~B; add_c = 1'b1; end
            OP_INC:  begin add_y = '0; add_c = 1'b1; end
            OP_DEC:  add_y = '1;
            OP_NEG:  begin add_x = ~A; add_y = '0; add_c = 1'b1; end
            OP_ADDC: add_c = cin;
            default: ;
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_c};
    assign eq  = (A == B);

    always_comb begin
        F         = '0;
        G         = '0;
        carry_out = 1'b0;
        ovf       = 1'b0;
        err       = 1'b0;
        if (MODE == MODE_ARITH) begin
            if (S <= OP_ADDC) begin
                F         = sum[WIDTH-1:0];
                carry_out = sum[WIDTH];
                ovf       = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
                if (S == OP_ADD || S == OP_SUB || S == OP_ADDC) G = A;
            end else begin
                F   = A;
                err = 1'b1;
            end
        end else begin
            case (S)
                OP_AND:   F = A & B;
                OP_OR:    F = A | B;
                OP_XOR:   begin F = A ^ B; G = A; end
                OP_XNOR:  F = ~(A ^ B);
                OP_NOT:   F = ~A;
                OP_NAND:  F = ~(A & B);
                OP_NOR:   F = ~(A | B);
                OP_PASSB: F = B;
                OP_SHL:   begin F = {A[WIDTH-2:0], 1'b0}; carry_out = A[WIDTH-1]; end
                OP_SHR:   begin F = {1'b0, A[WIDTH-1:1]}; carry_out = A[0]; end
                OP_ROL:   F = {A[WIDTH-2:0], A[WIDTH-1]};
                OP_ROR:   F = {A[0], A[WIDTH-1:1]};
                default:  err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/reversible_alu_pipe.sv
// Two-stage valid/ready wrapper around reversible_alu_core with a sticky carry for multi-word ADDC chains.
module reversible_alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             MODE,
    input  logic             carry_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] G,
    output logic             carry_out,
    output logic             zero_flag,
    output logic             eq_flag,
    output logic             ovf_flag,
    output logic             err
);

    typedef struct packed {
        logic [WIDTH-1:0] f;
        logic [WIDTH-1:0] g;
        logic             carry;
        logic             zero;
        logic             eq;
        logic             ovf;
        logic             err;
    } beat_t;

    logic [WIDTH-1:0] core_f;
    logic [WIDTH-1:0] core_g;
    logic             core_c;
    logic             core_ovf;
    logic             core_err;
    logic             core_eq;
    logic             cin;
    logic             advance;
    logic             accept;

    beat_t core_beat;
    beat_t s1_d, s1_q, out_d, out_q;
    logic  s1_valid_d, s1_valid_q;
    logic  out_valid_d, out_valid_q;
    logic  carry_d, carry_q;

    assign advance = !out_valid_q || out_ready;
    assign accept  = in_valid && advance;
    assign cin     = carry_clr ? 1'b0 : carry_q;

    reversible_alu_core #(.WIDTH(WIDTH)) u_core (
        .A         (A),
        .B         (B),
        .S         (S),
        .MODE      (MODE),
        .cin       (cin),
        .F         (core_f),
        .G         (core_g),
        .carry_out (core_c),
        .ovf       (core_ovf),
        .err       (core_err),
        .eq        (core_eq)
    );

    assign core_beat = '{f: core_f, g: core_g, carry: core_c, zero: (core_f == '0),
                         eq: core_eq, ovf: core_ovf, err: core_err};

    always_comb begin
        s1_d        = s1_q;
        s1_valid_d  = s1_valid_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        carry_d     = carry_q;
        if (advance) begin
            s1_valid_d  = in_valid;
            out_valid_d = s1_valid_q;
            if (in_valid)   s1_d  = core_beat;
            if (s1_valid_q) out_d = s1_q;
        end
        // Carry updates at acceptance, so a back-to-back ADDC already sees it through cin.
        if (accept) begin
            if (MODE == MODE_ARITH && !core_err) carry_d = core_c;
            else if (carry_clr)                  carry_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign F         = out_q.f;
    assign G         = out_q.g;
    assign carry_out = out_q.carry;
    assign zero_flag = out_q.zero;
    assign eq_flag   = out_q.eq;
    assign ovf_flag  = out_q.ovf;
    assign err       = out_q.err;

endmodule

// File: tb/tb_reversible_alu_pipe.sv
// Directed bench for reversible_alu_pipe: scoreboard of modelled results plus timing/stall/reset checks.
module tb_reversible_alu_pipe;

    typedef struct packed {
        logic [31:0] f;
        logic [31:0] g;
        logic        c;
        logic        z;
        logic        e;
        logic        o;
        logic        r;
    } res_t;

    localparam longint MAXP = 64'sd2147483647;
    localparam longint MINN = -64'sd2147483648;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, MODE, carry_clr, out_valid, out_ready;
    logic [31:0] A, B, F, G;
    logic [3:0]  S;
    logic        carry_out, zero_flag, eq_flag, ovf_flag, err;

    logic       iv8, ir8, m8, clr8, ov8, ordy8;
    logic [7:0] a8, b8, f8, g8;
    logic [3:0] s8;
    logic       c8, z8, e8, o8, r8;

    res_t scb[$];
    res_t obs, exp_r;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    logic mc     = 1'b0;

    reversible_alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .S(S), .MODE(MODE), .carry_clr(carry_clr),
        .out_valid(out_valid), .out_ready(out_ready), .F(F), .G(G),
        .carry_out(carry_out), .zero_flag(zero_flag), .eq_flag(eq_flag),
        .ovf_flag(ovf_flag), .err(err)
    );

    reversible_alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .S(s8), .MODE(m8), .carry_clr(clr8),
        .out_valid(ov8), .out_ready(ordy8), .F(f8), .G(g8),
        .carry_out(c8), .zero_flag(z8), .eq_flag(e8),
        .ovf_flag(o8), .err(r8)
    );

    assign obs = {F, G, carry_out, zero_flag, eq_flag, ovf_flag, err};

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] s, input logic m, input logic cin);
        res_t        x;
        logic [32:0] u;
        longint      sv, sa, sbv;
        x   = '0;
        u   = '0;
        sv  = 0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (!m) begin
            case (s)
                4'd0: begin u = {1'b0, a} + {1'b0, b};          sv = sa + sbv;       x.g = a; end
                4'd1: begin u = {1'b0, a} + {1'b0, ~b} + 33'd1; sv = sa - sbv;       x.g = a; end
                4'd2: begin u = {1'b0, a} + 33'd1;              sv = sa + 1;         end
                4'd3: begin u = {1'b0, a} + 33'h0FFFFFFFF;      sv = sa - 1;         end
                4'd4: begin u = {1'b0, ~a} + 33'd1;             sv = -sa;            end
                4'd5: begin u = {1'b0, a} + {1'b0, b} + {32'd0, cin}; sv = sa + sbv + (cin ? 1 : 0); x.g = a; end
                default: begin u = {1'b0, a}; x.r = 1'b1; end
            endcase
            x.f = u[31:0];
            x.c = u[32];
            x.o = !x.r && (sv > MAXP || sv < MINN);
        end else begin
            case (s)
                4'd0:  x.f = a & b;
                4'd1:  x.f = a | b;
                4'd2:  begin x.f = a ^ b; x.g = a; end
                4'd3:  x.f = ~(a ^ b);
                4'd4:  x.f = ~a;
                4'd5:  x.f = ~(a & b);
                4'd6:  x.f = ~(a | b);
                4'd7:  x.f = b;
                4'd8:  begin x.f = a << 1; x.c = a[31]; end
                4'd9:  begin x.f = a >> 1; x.c = a[0]; end
                4'd10: x.f = {a[30:0], a[31]};
                4'd11: x.f = {a[0], a[31:1]};
                default: x.r = 1'b1;
            endcase
        end
        x.z = (x.f == 32'd0);
        x.e = (a == b);
        return x;
    endfunction

    // Scoreboard: push on acceptance, pop on output handshake; reset discards everything in flight.
    always @(negedge clk) begin
        if (rst) begin
            scb.delete();
            mc = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                if (scb.size() == 0) begin
                    errors++;
                    $error("FAIL sb_unexpected: got %h expected no beat", obs);
                end else begin
                    exp_r = scb.pop_front();
                    assert (obs === exp_r) else begin
                        errors++;
                        $error("FAIL sb_beat%0d: got %h expected %h", n_out, obs, exp_r);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_r = model(A, B, S, MODE, carry_clr ? 1'b0 : mc);
                scb.push_back(exp_r);
                if (!MODE && !exp_r.r) mc = exp_r.c;
                else if (carry_clr)    mc = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                        input logic m, input logic clr);
        logic took;
        took = 1'b0;
        A = a; B = b; S = s; MODE = m; carry_clr = clr; in_valid = 1'b1;
        for (int i = 0; i < 16 && !took; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("send_accepted", {63'd0, took}, 64'd1);
    endtask

    int   n_snap;
    logic took;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; S = '0; MODE = 1'b0; carry_clr = 1'b0;
        iv8 = 1'b0; ordy8 = 1'b1; a8 = '0; b8 = '0; s8 = '0; m8 = 1'b0; clr8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_F", {32'd0, F}, 64'd0);
        chk("rst_G", {32'd0, G}, 64'd0);
        chk("rst_flags", {59'd0, carry_out, zero_flag, eq_flag, ovf_flag, err}, 64'd0);
        chk("rst_out_valid8", {63'd0, ov8}, 64'd0);

        // 1: ADD 5+3 and two-edge latency
        send(32'd5, 32'd3, 4'd0, 1'b0, 1'b0);
        chk("lat_edge1", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk("lat_edge2", {63'd0, out_valid}, 64'd1);
        repeat (2) @(posedge clk); #1;

        // 2: ADD carry then back-to-back ADDC
        send(32'hFFFF_FFFF, 32'd1, 4'd0, 1'b0, 1'b0);
        send(32'd0, 32'd0, 4'd5, 1'b0, 1'b0);
        repeat (3) @(posedge clk); #1;

        // 3: WIDTH=8 SUB and NEG on the most-negative value
        a8 = 8'h80; b8 = 8'h01; s8 = 4'd1; m8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h80; b8 = 8'h00; s8 = 4'd4;
        @(posedge clk); #1;
        iv8 = 1'b0;
        chk("w8_sub_valid", {63'd0, ov8}, 64'd1);
        chk("w8_sub_F", {56'd0, f8}, 64'h7F);
        chk("w8_sub_ovf_c", {62'd0, o8, c8}, 64'd3);
        @(posedge clk); #1;
        chk("w8_neg_F", {56'd0, f8}, 64'h80);
        chk("w8_neg_ovf_c", {62'd0, o8, c8}, 64'd2);

        // 4: stall with out_ready low while streaming XOR, OR, AND
        out_ready = 1'b0;
        send(32'hF0F0_1234, 32'h0FF0_00FF, 4'd2, 1'b1, 1'b0);
        send(32'h1200_0034, 32'h0000_5600, 4'd1, 1'b1, 1'b0);
        A = 32'hFFFF_0000; B = 32'h0F0F_0F0F; S = 4'd0; MODE = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_F", {32'd0, F}, {32'd0, model(32'hF0F0_1234, 32'h0FF0_00FF, 4'd2, 1'b1, 1'b0).f});
        end
        out_ready = 1'b1;
        took = 1'b0;
        for (int i = 0; i < 8 && !took; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stall_release", {63'd0, took}, 64'd1);
        repeat (4) @(posedge clk); #1;

        // 5: error ops leave carry_q alone
        send(32'hFFFF_FFFF, 32'd1, 4'd0, 1'b0, 1'b0);
        send(32'd5, 32'd6, 4'd13, 1'b1, 1'b0);
        send(32'd7, 32'd7, 4'd9, 1'b0, 1'b0);
        send(32'd0, 32'd0, 4'd5, 1'b0, 1'b0);
        repeat (4) @(posedge clk); #1;

        // 6: reset with two beats in flight
        out_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'd1, 4'd0, 1'b0, 1'b0);
        send(32'd1, 32'd2, 4'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_F", {32'd0, F}, 64'd0);
        n_snap = n_out;
        out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("midrst_no_emit", 64'(n_out), 64'(n_snap));
        send(32'd0, 32'd0, 4'd5, 1'b0, 1'b0);
        repeat (4) @(posedge clk); #1;

        chk("sb_drained", 64'(scb.size()), 64'd0);
        chk("beats_out", 64'(n_out), 64'd11);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
